// File: rtl/instr_fetch_pkg.sv
// Shared types and code-word layout for the fetch/decode front end.
// The field slices let the decoder split a word the same way fetch does.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int OP_SIZE    = 4;
    localparam int PA_SIZE    = 4;
    localparam int PB_SIZE    = 4;
    localparam int ADDR_SIZE  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = OP_SIZE + PA_SIZE + PB_SIZE;

    localparam logic [OP_SIZE-1:0] HALT_OP = 4'hF;

    localparam int OP_MSB = CW - 1;
    localparam int OP_LSB = CW - OP_SIZE;
    localparam int PA_MSB = OP_LSB - 1;
    localparam int PA_LSB = PB_SIZE;
    localparam int PB_MSB = PB_SIZE - 1;
    localparam int PB_LSB = 0;

    function automatic logic [OP_SIZE-1:0] opcode_of(input logic [CW-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port plus the code handshake toward the decoder.
// Master is the fetch unit; slave is the memory/decoder side.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int DW = CW,
    parameter int AW = ADDR_SIZE
) ();

    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] code;
    logic          code_valid;
    logic          code_ready;

    modport master (
        output mem_en, mem_addr, code, code_valid,
        input  mem_data, code_ready
    );

    modport slave (
        input  mem_en, mem_addr, code, code_valid,
        output mem_data, code_ready
    );

endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO buffering fetched code words.
// Depth must be a power of two so the pointers wrap for free.
module instr_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= wdata_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop_i) head_q <= head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));

    // Credit-based issue upstream should make this unreachable.
    assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: walks pc over a 1-cycle-latency instruction memory,
// buffers words for the decoder, stops at length or halt, pulses done.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                 op_size      = OP_SIZE,
    parameter int                 param_a_size = PA_SIZE,
    parameter int                 param_b_size = PB_SIZE,
    parameter int                 addr_size    = ADDR_SIZE,
    parameter int                 fifo_depth   = FIFO_DEPTH,
    parameter logic [op_size-1:0] halt_op      = HALT_OP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] prog_len,
    instr_fetch_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic [addr_size-1:0] pc
);

    localparam int cw    = op_size + param_a_size + param_b_size;
    localparam int cnt_w = $clog2(fifo_depth) + 1;

    state_e               state_q, state_d;
    logic [addr_size-1:0] pc_q, pc_d;
    logic [addr_size-1:0] len_q, len_d;
    logic                 inflight_q, inflight_d;
    logic                 halted_q, halted_d;

    logic [cnt_w-1:0]     count;
    logic [cnt_w:0]       credit;
    logic                 empty, full;
    logic                 issue, push, pop, halt_hit;

    // A read landing after a halt was captured is dropped, not buffered.
    assign push     = inflight_q && !halted_q;
    assign halt_hit = push && (bus.mem_data[cw-1 -: op_size] == halt_op);
    assign pop      = bus.code_valid && bus.code_ready;
    assign credit   = {1'b0, count} + {{cnt_w{1'b0}}, inflight_q};
    assign issue    = (state_q == FETCH) && (pc_q < len_q) && !halted_q
                   && (credit < (cnt_w+1)'(fifo_depth));

    instr_fifo #(
        .WIDTH (cw),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (bus.mem_data),
        .pop_i   (pop),
        .rdata_o (bus.code),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    assign bus.code_valid = !empty;
    assign bus.mem_en     = issue;
    assign bus.mem_addr   = pc_q;
    assign busy           = (state_q != IDLE);
    assign pc             = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        inflight_d = issue;
        halted_d   = halted_q | halt_hit;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d     = '0;
                    len_d    = prog_len;
                    halted_d = 1'b0;
                    state_d  = (prog_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue) pc_d = pc_q + 1'b1;
                if ((pc_d == len_q) || halted_d) state_d = DRAIN;
            end
            DRAIN: begin
                if (empty && !inflight_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream stage of the instruction decoder.
- Walks a program counter over a synchronous instruction memory and buffers the returned code words in a small FIFO.
- Presents each word with a valid/ready handshake to the decoder, whose code input is op_size+param_a_size+param_b_size bits with the opcode in the MSBs.
- Stops at the program length or at a halt opcode, drains the buffer, then pulses done.

Parameters:
- op_size, 4, opcode field width (MSBs of a code word)
- param_a_size, 4, parameter-A field width
- param_b_size, 4, parameter-B field width
- addr_size, 8, instruction memory address width
- fifo_depth, 4, code buffer entries (power of two, >=2)
- halt_op, 4'hF, opcode that terminates fetch

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin fetch at address 0 (sampled in IDLE only)
- prog_len  input  addr_size  number of words to fetch, sampled on start
- mem_en  output  1  instruction memory read enable
- mem_addr  output  addr_size  instruction memory read address
- mem_data  input  CW  read data, valid the cycle after mem_en; CW = op_size+param_a_size+param_b_size
- code  output  CW  FIFO head word to the decoder
- code_valid  output  1  FIFO non-empty
- code_ready  input  1  decoder accepts code this cycle
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the program is fully delivered
- pc  output  addr_size  next address to be issued

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0. State IDLE, FIFO empty, in-flight flag 0, stored length 0.
- States:
  - IDLE -> FETCH on start: pc=0, latch prog_len. If prog_len==0, go IDLE -> DONE instead.
  - FETCH: issue a read (mem_en=1, mem_addr=pc, pc++) when pc<len, no halt has been captured, and count+inflight<fifo_depth.
  - FETCH -> DRAIN when no further issue is possible: pc==len, or a halt is captured.
  - DRAIN -> DONE when the FIFO is empty and nothing is in flight.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Memory read:
  - 1-cycle latency. inflight register is set on issue. The next cycle mem_data is pushed into the FIFO at the tail.
  - At most one read is outstanding per cycle, so back-to-back issue gives one word per cycle.
- Halt:
  - If a pushed word has opcode field (MSBs) == halt_op, the word is still pushed so the decoder sees it, and issue stops immediately.
  - A word already in flight when the halt lands is discarded, not pushed.
- FIFO:
  - head/tail pointers wrap modulo fifo_depth; count ranges 0..fifo_depth.
  - Pop when code_valid && code_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full: the credit rule makes overflow impossible. An assertion flags push while full.
- Handshake: code and code_valid hold stable while code_valid && !code_ready.
- start is ignored outside IDLE.
- pc stops at len and does not wrap. prog_len = 2^addr_size - 1 is the maximum program.
- Reset mid-operation: immediate return to IDLE. FIFO is flushed, the in-flight read is dropped, and done is not pulsed.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, DRAIN, DONE)
  - code-word width constant CW
  - halt_op default
  - field-slice localparams for the opcode MSBs, shared with the decoder
- One sub-module: instr_fifo, a synchronous FIFO with push/pop/count/empty/full, parameterised on width and depth.

Test Plan:
- Program of 3 words 0x123, 0x456, 0x789 with code_ready=1 -> mem_addr 0,1,2 on consecutive cycles. code shows each word in order, one per cycle starting 2 cycles after start. done pulses once. busy falls the cycle after done.
- Same 3 words with code_ready held 0 for 10 cycles -> fetch stalls with count==3. mem_en never fires with count+inflight==4. After release, all words arrive in order with none lost.
- prog_len=6 where word 2 is 0xF00 (halt) -> decoder receives 0xXXX, 0xXXX, 0xF00 only. No mem_addr above 3 is issued; word 3, if in flight, is discarded. Then done.
- prog_len=0 with start -> no mem_en. done pulses the cycle after IDLE->DONE. code_valid stays 0.
- rst asserted mid-FETCH with 2 words buffered -> all outputs 0 immediately, no done pulse. A new start refetches from address 0.
- start pulsed while busy -> ignored; pc and len are unchanged.
